// File: rtl/hex_scroll_ctrl.sv
`default_nettype none
// hex_scroll_ctrl: debounced run/load keys, LOAD/PAUSE/RUN sequencing, speed-selected
// step tick and ping-pong direction scheduling for the 6-digit hex scroll datapath.
module hex_scroll_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int BOUNCE_STEPS = 6
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       key_run_n,
  input  logic       key_load_n,
  input  logic [1:0] sw_speed,
  input  logic [1:0] sw_mode,
  output logic       load_en,
  output logic       shift_en,
  output logic       shift_dir,
  output logic       running,
  output logic [2:0] step_cnt
);

  localparam int TW = $clog2(CLK_HZ);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [2:0]    STEP_LAST = 3'(BOUNCE_STEPS - 1);
  localparam logic [TW-1:0] LIM_1HZ   = TW'(CLK_HZ - 1);
  localparam logic [TW-1:0] LIM_2HZ   = TW'(CLK_HZ / 2 - 1);
  localparam logic [TW-1:0] LIM_4HZ   = TW'(CLK_HZ / 4 - 1);
  localparam logic [TW-1:0] LIM_8HZ   = TW'(CLK_HZ / 8 - 1);
  localparam logic [1:0]    MODE_PONG = 2'b10;
  localparam logic [1:0]    MODE_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0] key_raw;
  logic [1:0] press;  // bit 0 = run, bit 1 = load

  assign key_raw = {key_load_n, key_run_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == DEB_LAST) begin
          level_d = sync2_q;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        level_q <= 1'b1;
        cnt_q   <= '0;
      end else begin
        sync1_q <= key_raw[k];
        sync2_q <= sync1_q;
        level_q <= level_d;
        cnt_q   <= cnt_d;
      end
    end

    assign press[k] = level_q & ~level_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:  state_d = ST_PAUSE;
      ST_PAUSE: if (press[0]) state_d = ST_RUN;
      ST_RUN:   if (press[0]) state_d = ST_PAUSE;
      default:  state_d = ST_LOAD;
    endcase
    if (press[1]) begin
      state_d = ST_LOAD;
    end
  end

  logic [TW-1:0] tick_q, tick_d, limit;
  logic [1:0]    speed_q;
  logic [2:0]    step_q, step_d;
  logic          dir_q, dir_d;
  logic          fire;
  logic          shift_en_q, shift_en_d;
  logic          shift_dir_q, shift_dir_d;
  logic          load_en_q, running_q;

  always_comb begin
    unique case (sw_speed)
      2'd0:    limit = LIM_1HZ;
      2'd1:    limit = LIM_2HZ;
      2'd2:    limit = LIM_4HZ;
      default: limit = LIM_8HZ;
    endcase
  end

  always_comb begin
    tick_d      = tick_q;
    step_d      = step_q;
    dir_d       = dir_q;
    fire        = 1'b0;
    shift_en_d  = 1'b0;
    shift_dir_d = shift_dir_q;

    // A speed change restarts the phase and suppresses any shift that cycle.
    if (state_q == ST_LOAD) begin
      tick_d = '0;
      step_d = '0;
      dir_d  = 1'b0;
    end else if (sw_speed != speed_q) begin
      tick_d = '0;
    end else if (state_q == ST_RUN && sw_mode != MODE_HOLD) begin
      if (tick_q == limit) begin
        tick_d = '0;
        fire   = 1'b1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    if (fire) begin
      shift_en_d = 1'b1;
      if (sw_mode == MODE_PONG) begin
        shift_dir_d = dir_q;
        if (step_q == STEP_LAST) begin
          step_d = '0;
          dir_d  = ~dir_q;
        end else begin
          step_d = step_q + 3'd1;
        end
      end else begin
        shift_dir_d = sw_mode[0];
      end
    end

    // Leaving ping-pong parks the leg state, so re-entry always starts rightward.
    if (sw_mode != MODE_PONG) begin
      step_d = '0;
      dir_d  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_LOAD;
      tick_q      <= '0;
      speed_q     <= '0;
      step_q      <= '0;
      dir_q       <= 1'b0;
      shift_en_q  <= 1'b0;
      shift_dir_q <= 1'b0;
      load_en_q   <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      speed_q     <= sw_speed;
      step_q      <= step_d;
      dir_q       <= dir_d;
      shift_en_q  <= shift_en_d;
      shift_dir_q <= shift_dir_d;
      load_en_q   <= (state_q == ST_LOAD);
      running_q   <= (state_d == ST_RUN);
    end
  end

  assign load_en   = load_en_q;
  assign shift_en  = shift_en_q;
  assign shift_dir = shift_dir_q;
  assign running   = running_q;
  assign step_cnt  = step_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_ctrl.sv
`default_nettype none
// tb_hex_scroll_ctrl: randomized key/switch stimulus checked every cycle against a
// behavioural model of the scroll controller.
module tb_hex_scroll_ctrl;

  localparam int CLK_HZ = 16;
  localparam int DEB    = 4;
  localparam int BSTEPS = 3;
  localparam int S_LOAD = 0, S_PAUSE = 1, S_RUN = 2;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       key_run_n  = 1'b1;
  logic       key_load_n = 1'b1;
  logic [1:0] sw_speed   = 2'd0;
  logic [1:0] sw_mode    = 2'd0;
  logic       load_en, shift_en, shift_dir, running;
  logic [2:0] step_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hex_scroll_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_CYC(DEB),
    .BOUNCE_STEPS(BSTEPS)
  ) dut (
    .CLOCK_50  (clk),
    .RST_N     (rst_n),
    .key_run_n (key_run_n),
    .key_load_n(key_load_n),
    .sw_speed  (sw_speed),
    .sw_mode   (sw_mode),
    .load_en   (load_en),
    .shift_en  (shift_en),
    .shift_dir (shift_dir),
    .running   (running),
    .step_cnt  (step_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit pipe_r[$];
  bit pipe_l[$];
  bit lvl_r, lvl_l;
  int streak_r, streak_l;
  int st, phase, prev_speed, pong;
  bit e_load, e_shift, e_dir, e_run;
  int e_step;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe_r = '{1'b1, 1'b1};
    pipe_l = '{1'b1, 1'b1};
    lvl_r = 1'b1; lvl_l = 1'b1;
    streak_r = 0; streak_l = 0;
    st = S_LOAD; phase = 0; prev_speed = 0; pong = 0;
    e_load = 0; e_shift = 0; e_dir = 0; e_run = 0; e_step = 0;
  endtask

  task automatic deb(input bit seen, inout bit lvl, inout int streak, output bit pressed);
    pressed = 1'b0;
    if (seen != lvl) begin
      streak++;
      if (streak == DEB) begin
        pressed = lvl;
        lvl     = seen;
        streak  = 0;
      end
    end else begin
      streak = 0;
    end
  endtask

  task automatic model_step();
    bit pr, pl, fire, s;
    int period;
    s = pipe_r.pop_front(); deb(s, lvl_r, streak_r, pr); pipe_r.push_back(bit'(key_run_n));
    s = pipe_l.pop_front(); deb(s, lvl_l, streak_l, pl); pipe_l.push_back(bit'(key_load_n));

    period = CLK_HZ >> sw_speed;
    fire   = 1'b0;
    if (st == S_LOAD) begin
      phase = 0;
      pong  = 0;
    end else if (int'(sw_speed) != prev_speed) begin
      phase = 0;
    end else if (st == S_RUN && sw_mode != 2'd3) begin
      if (phase == period - 1) begin
        phase = 0;
        fire  = 1'b1;
      end else begin
        phase++;
      end
    end
    e_shift = fire;
    if (fire) begin
      if (sw_mode == 2'd2) begin
        e_dir = ((pong / BSTEPS) % 2) != 0;
        pong++;
      end else begin
        e_dir = sw_mode[0];
      end
    end
    if (sw_mode != 2'd2) pong = 0;
    e_step     = pong % BSTEPS;
    prev_speed = int'(sw_speed);

    e_load = (st == S_LOAD);
    if (pl)                st = S_LOAD;
    else if (st == S_LOAD) st = S_PAUSE;
    else if (pr)           st = (st == S_RUN) ? S_PAUSE : S_RUN;
    e_run = (st == S_RUN);
  endtask

  task automatic check_outputs();
    chk("load_en",  32'(load_en),  32'(e_load));
    chk("shift_en", 32'(shift_en), 32'(e_shift));
    chk("running",  32'(running),  32'(e_run));
    chk("step_cnt", 32'(step_cnt), 32'(e_step));
    if (e_shift) chk("shift_dir", 32'(shift_dir), 32'(e_dir));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
    end
  endtask

  task automatic keys(input logic r, input logic l, input int n);
    key_run_n  = r;
    key_load_n = l;
    cycles(n);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_load_en"},  32'(load_en),  32'd0);
    chk({tag, "_shift_en"}, 32'(shift_en), 32'd0);
    chk({tag, "_shift_dir"},32'(shift_dir),32'd0);
    chk({tag, "_running"},  32'(running),  32'd0);
    chk({tag, "_step_cnt"}, 32'(step_cnt), 32'd0);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    cycles(100);

    // Glitchy run key followed by a clean press
    keys(1'b0, 1'b1, 2); keys(1'b1, 1'b1, 2);
    keys(1'b0, 1'b1, 2); keys(1'b1, 1'b1, 2);
    keys(1'b0, 1'b1, 10); keys(1'b1, 1'b1, 10);
    chk("run_after_press", 32'(running), 32'd1);
    cycles(60);

    sw_speed = 2'd3; cycles(20);
    sw_mode  = 2'd2; cycles(30);

    for (int seg = 0; seg < 150; seg++) begin
      int act;
      act = int'($urandom_range(0, 9));
      case (act)
        0, 1, 2, 3: begin
          keys(1'b0, 1'b1, int'($urandom_range(1, 9)));
          keys(1'b1, 1'b1, int'($urandom_range(1, 40)));
        end
        4: begin
          keys(1'b1, 1'b0, int'($urandom_range(1, 9)));
          keys(1'b1, 1'b1, int'($urandom_range(1, 30)));
        end
        5: begin
          sw_speed = 2'($urandom_range(0, 3));
          cycles(int'($urandom_range(1, 30)));
        end
        6, 7: begin
          sw_mode = 2'($urandom_range(0, 3));
          cycles(int'($urandom_range(1, 40)));
        end
        default: cycles(int'($urandom_range(10, 60)));
      endcase
    end

    // Run and load debounced together: load wins
    keys(1'b1, 1'b1, 10);
    keys(1'b0, 1'b0, 8);
    keys(1'b1, 1'b1, 8);
    chk("both_press_running", 32'(running), 32'd0);

    // Asynchronous reset while running
    sw_mode = 2'd0; sw_speed = 2'd3;
    for (int a = 0; a < 4 && st != S_RUN; a++) begin
      keys(1'b0, 1'b1, 8);
      keys(1'b1, 1'b1, 8);
    end
    chk("pre_reset_running", 32'(running), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    cycles(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
